// File: rtl/if_stage_pkg.sv
// Shared fetch-side definitions: FSM states, reset PC, NPC ops.
// Also defines the IF/ID bundle type.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } if_state_e;

  typedef enum logic [1:0] {
    NPC_PC4 = 2'd0,
    NPC_BR  = 2'd1,
    NPC_JAL = 2'd2,
    NPC_JR  = 2'd3
  } npc_op_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] p);
    return p + 32'd4;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched word while IF/ID is stalled.
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_valid
);

  logic [31:0] r_data;
  logic        r_vld;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data <= '0;
      r_vld  <= 1'b0;
    end else if (i_clear) begin
      r_vld  <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_vld  <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_vld;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, fetch FSM, redirect target and IF/ID.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] npc,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  if_state_e   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_tgt;
  if_id_t      r_ifid;

  logic        w_deliver;
  logic        w_skid_load;
  logic        w_skid_clr;
  logic        w_skid_vld;
  logic [31:0] w_skid_data;
  logic [31:0] w_instr;

  if_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clr),
    .i_data  (imem_rdata),
    .o_data  (w_skid_data),
    .o_valid (w_skid_vld)
  );

  always_comb begin
    w_deliver   = 1'b0;
    w_skid_load = 1'b0;
    w_skid_clr  = 1'b0;
    w_instr     = imem_rdata;
    case (r_state)
      S_FETCH: begin
        w_deliver   = imem_rdy & ~redirect & ~stall;
        w_skid_load = imem_rdy & ~redirect & stall;
      end
      S_HOLD: begin
        w_deliver  = w_skid_vld & ~redirect & ~stall;
        w_skid_clr = redirect | ~stall;
        w_instr    = w_skid_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_tgt   <= '0;
      r_ifid  <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (redirect) begin
            if (imem_rdy) begin
              r_pc <= npc;
            end else begin
              r_tgt   <= npc;
              r_state <= S_DROP;
            end
          end else if (imem_rdy) begin
            if (stall) r_state <= S_HOLD;
            else       r_pc    <= pc_inc(r_pc);
          end
        end
        S_HOLD: begin
          if (redirect) begin
            r_pc    <= npc;
            r_state <= S_FETCH;
          end else if (!stall) begin
            r_pc    <= pc_inc(r_pc);
            r_state <= S_FETCH;
          end
        end
        S_DROP: begin
          // A redirect landing with the response wins over the saved target
          if (redirect) r_tgt <= npc;
          if (imem_rdy) begin
            r_pc    <= redirect ? npc : r_tgt;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase

      if (flush) begin
        r_ifid.valid <= 1'b0;
      end else if (!stall) begin
        if (w_deliver) r_ifid <= '{valid: 1'b1, pc: r_pc, instr: w_instr};
        else           r_ifid.valid <= 1'b0;
      end
    end
  end

  assign pc          = r_pc;
  assign imem_addr   = r_pc;
  assign imem_req    = (r_state != S_HOLD);
  assign if_id_valid = r_ifid.valid;
  assign if_id_pc    = r_ifid.pc;
  assign if_id_instr = r_ifid.instr;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an IF/ID expectation queue.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] npc;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_rdata = imem_rdy ? mem(imem_addr) : 32'hDEAD_BEEF;

  if_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .npc         (npc),
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_rdata  (imem_rdata),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // push the IF/ID expected after the next edge, clock, then pop+compare
  task automatic cyc(input logic v, input logic [31:0] epc);
    exp_t e;
    sb.push_back('{v: v, pc: epc, instr: mem(epc)});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("ifid_valid", {31'd0, if_id_valid}, {31'd0, e.v});
    if (e.v) begin
      chk("ifid_pc", if_id_pc, e.pc);
      chk("ifid_instr", if_id_instr, e.instr);
    end
  endtask

  task automatic st(input string tag, input if_state_e s);
    chk(tag, {30'd0, dut.r_state}, {30'd0, s});
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    redirect = 1'b0; npc = '0; imem_rdy = 1'b0;

    // reset state
    cyc(1'b0, 32'h0);
    cyc(1'b0, 32'h0);
    chk("rst_pc", pc, 32'h3000);
    chk("rst_ifid_pc", if_id_pc, 32'h0);
    chk("rst_ifid_instr", if_id_instr, 32'h0);
    rst = 1'b1;
    chk("req_after_rst", {31'd0, imem_req}, 32'd1);

    // zero-wait streaming
    imem_rdy = 1'b1;
    cyc(1'b1, 32'h3000);
    chk("seq_pc1", pc, 32'h3004);
    cyc(1'b1, 32'h3004);
    chk("seq_pc2", pc, 32'h3008);
    cyc(1'b1, 32'h3008);

    // 3-cycle wait after reset
    rst = 1'b0; imem_rdy = 1'b0;
    cyc(1'b0, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("wait_addr", imem_addr, 32'h3000);
      cyc(1'b0, 32'h0);
    end
    imem_rdy = 1'b1;
    cyc(1'b1, 32'h3000);
    chk("wait_pc", pc, 32'h3004);

    // stall during response -> skid buffer
    stall = 1'b1;
    cyc(1'b1, 32'h3000);
    st("hold_state", S_HOLD);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_pc", pc, 32'h3004);
    imem_rdy = 1'b0;
    cyc(1'b1, 32'h3000);
    st("hold_state2", S_HOLD);
    stall = 1'b0;
    cyc(1'b1, 32'h3004);
    chk("rel_pc", pc, 32'h3008);
    st("rel_state", S_FETCH);

    // redirect with request outstanding
    redirect = 1'b1; npc = 32'h3100;
    cyc(1'b0, 32'h0);
    st("drop_state", S_DROP);
    chk("drop_addr", imem_addr, 32'h3008);
    chk("drop_req", {31'd0, imem_req}, 32'd1);
    redirect = 1'b0;
    cyc(1'b0, 32'h0);
    imem_rdy = 1'b1;
    cyc(1'b0, 32'h0);
    chk("drop_new_addr", imem_addr, 32'h3100);
    cyc(1'b1, 32'h3100);

    // redirect coinciding with response
    redirect = 1'b1; npc = 32'h3200;
    cyc(1'b0, 32'h0);
    chk("redir_pc", pc, 32'h3200);
    redirect = 1'b0;
    cyc(1'b1, 32'h3200);

    // flush + stall on valid IF/ID, no response pending
    flush = 1'b1; stall = 1'b1; imem_rdy = 1'b0;
    cyc(1'b0, 32'h0);
    chk("flush_pc", pc, 32'h3204);
    st("flush_state", S_FETCH);
    flush = 1'b0;

    // reset while in HOLD
    imem_rdy = 1'b1;
    cyc(1'b0, 32'h0);
    st("hold2_state", S_HOLD);
    rst = 1'b0; stall = 1'b0; imem_rdy = 1'b0;
    cyc(1'b0, 32'h0);
    chk("rsth_pc", pc, 32'h3000);
    st("rsth_state", S_FETCH);
    chk("rsth_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;

    // redirect out of HOLD beats stall release
    imem_rdy = 1'b1;
    cyc(1'b1, 32'h3000);
    stall = 1'b1;
    cyc(1'b1, 32'h3000);
    st("hold3_state", S_HOLD);
    redirect = 1'b1; npc = 32'h3400;
    cyc(1'b1, 32'h3000);
    chk("hredir_pc", pc, 32'h3400);
    st("hredir_state", S_FETCH);
    redirect = 1'b0; stall = 1'b0;
    cyc(1'b1, 32'h3400);

    // double redirect in DROP keeps the newest target
    imem_rdy = 1'b0; redirect = 1'b1; npc = 32'h3500;
    cyc(1'b0, 32'h0);
    npc = 32'h3600;
    cyc(1'b0, 32'h0);
    redirect = 1'b0; imem_rdy = 1'b1;
    cyc(1'b0, 32'h0);
    chk("drop2_pc", pc, 32'h3600);

    // pc wraps mod 2^32
    redirect = 1'b1; npc = 32'hFFFF_FFFC;
    cyc(1'b0, 32'h0);
    redirect = 1'b0;
    cyc(1'b1, 32'hFFFF_FFFC);
    chk("wrap_pc", pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
